// File: rtl/xmint_rr_arbiter.sv
// Round-robin arbiter sharing one registered output channel between N requesters.
// A grant stays locked to one requester from its first beat until its last beat is accepted.
module xmint_rr_arbiter #(
   parameter int N              = 3,
   parameter int MUX_DATA_WIDTH = 32,
   localparam int SEL_W         = $clog2(N)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [N-1:0]                        req_valid,
   input  logic [N-1:0][MUX_DATA_WIDTH-1:0]    req_data,
   input  logic [N-1:0]                        req_last,
   output logic [N-1:0]                        req_ready,
   output logic                                out_valid,
   output logic [MUX_DATA_WIDTH-1:0]           out_data,
   output logic [SEL_W-1:0]                    out_src,
   output logic                                out_last,
   input  logic                                out_ready,
   output logic                                locked
);

   // Handshake: a beat moves on a rising edge where valid and ready are both high;
   // req_ready never depends on req_data/req_last, and out_* come only from registers.
   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

   state_e                      state_q, state_d;
   logic [SEL_W-1:0]            ptr_q, ptr_d;
   logic [SEL_W-1:0]            owner_q, owner_d;
   logic                        out_valid_q, out_valid_d;
   logic [MUX_DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [SEL_W-1:0]            out_src_q, out_src_d;
   logic                        out_last_q, out_last_d;

   logic                        load_en;
   logic                        win_found;
   logic [SEL_W-1:0]            win_idx;
   logic [SEL_W-1:0]            cand;
   logic                        grant_valid;
   logic [SEL_W-1:0]            grant_idx;
   logic                        accept;

   // Walk candidates from ptr with an explicit wrap at N-1 so no illegal index is visited.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = ptr_q;
      for (int k = 0; k < N; k++) begin
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
         cand = (cand == LAST_IDX) ? '0 : cand + SEL_W'(1);
      end
   end

   always_comb begin
      load_en = !out_valid_q || out_ready;
      if (state_q == ST_LOCKED) begin
         grant_idx   = owner_q;
         grant_valid = req_valid[owner_q];
      end else begin
         grant_idx   = win_idx;
         grant_valid = win_found;
      end
      accept    = rst_n && load_en && grant_valid;
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_last_d  = out_last_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = req_data[grant_idx];
         out_src_d   = grant_idx;
         out_last_d  = req_last[grant_idx];
         if (req_last[grant_idx]) begin
            ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
            state_d = ST_ARB;
         end else begin
            owner_d = grant_idx;
            state_d = ST_LOCKED;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ARB;
         ptr_q       <= '0;
         owner_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_last  = out_last_q;
   assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_xmint_rr_arbiter.sv
// Bench for xmint_rr_arbiter: N=3 instance under directed and random traffic against a
// cycle-level reference model, plus a small N=5 instance exercising the non-power-of-two wrap.
module tb_xmint_rr_arbiter;

   localparam int N  = 3;
   localparam int W  = 32;
   localparam int SW = $clog2(N);
   localparam int EW = W + SW + 1;

   logic                clk;
   logic                rst_n;
   logic [N-1:0]        req_valid;
   logic [N-1:0][W-1:0] req_data;
   logic [N-1:0]        req_last;
   logic [N-1:0]        req_ready;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic [SW-1:0]       out_src;
   logic                out_last;
   logic                out_ready;
   logic                locked;

   logic [4:0]          v5;
   logic [4:0][W-1:0]   d5;
   logic [4:0]          l5;
   logic [4:0]          ready5;
   logic                ov5;
   logic [W-1:0]        od5;
   logic [2:0]          osrc5;
   logic                olast5;
   logic                or5;
   logic                lk5;

   int                  n_vec = 0;
   int                  n_err = 0;

   logic [EW-1:0]       exp_q[$];
   logic [2:0]          exp5_q[$];

   int                  m_ptr = 0;
   int                  m_owner = 0;
   bit                  m_locked = 0;
   bit                  m_out_valid = 0;
   int                  m_win;
   logic [N-1:0]        m_er;
   logic [N-1:0]        acc_vec = '0;

   bit                  pend_v[N];
   logic [W-1:0]        pend_d[N];
   logic                pend_l[N];
   logic [W-1:0]        nxt_data[N];
   logic                nxt_last[N];
   int                  acc_cnt[N];

   bit                  stall_prev = 0;
   logic [EW-1:0]       stall_snap;

   xmint_rr_arbiter #(.N(N), .MUX_DATA_WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
      .out_ready(out_ready), .locked(locked)
   );

   xmint_rr_arbiter #(.N(5), .MUX_DATA_WIDTH(W)) u_dut5 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v5), .req_data(d5), .req_last(l5), .req_ready(ready5),
      .out_valid(ov5), .out_data(od5), .out_src(osrc5), .out_last(olast5),
      .out_ready(or5), .locked(lk5)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Evaluated on the falling edge with inputs stable: predicts the ready vector,
   // then advances its own view of the arbiter across the coming rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_vec = '0;
      end else begin
         m_win = -1;
         if (m_locked) begin
            if (req_valid[m_owner]) m_win = m_owner;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            end
         end
         m_er = '0;
         if (m_win >= 0 && (!m_out_valid || out_ready)) m_er[m_win] = 1'b1;
         chk("req_ready", req_ready, m_er);
         chk("locked", locked, m_locked);
         chk("out_valid", out_valid, m_out_valid);
         acc_vec = m_er;
         if (m_er != '0) begin
            exp_q.push_back({req_last[m_win], SW'(m_win), req_data[m_win]});
            m_out_valid = 1;
            if (req_last[m_win]) begin
               m_ptr    = (m_win + 1) % N;
               m_locked = 0;
            end else begin
               m_owner  = m_win;
               m_locked = 1;
            end
         end else if (out_ready) begin
            m_out_valid = 0;
         end
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) chk("stall_hold", {out_last, out_src, out_data}, stall_snap);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL beat_unexpected: got src %0d data 0x%0h, expected no beat", out_src, out_data);
            end else begin
               chk("beat", {out_last, out_src, out_data}, exp_q.pop_front());
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_snap = {out_last, out_src, out_data};
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov5 && or5) begin
         if (exp5_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL n5_unexpected: got src %0d, expected no beat", osrc5);
         end else begin
            logic [2:0] e5;
            e5 = exp5_q.pop_front();
            chk("n5_src", osrc5, e5);
            chk("n5_data", od5, 32'h50 + 32'(e5));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rand_next(input logic [N-1:0] lm, input bit rl);
      for (int i = 0; i < N; i++) begin
         nxt_data[i] = $urandom;
         nxt_last[i] = rl ? 1'($urandom_range(0, 1)) : lm[i];
      end
   endtask

   // Called just after a rising edge; held beats stay stable until accepted.
   task automatic step(input logic [N-1:0] v_en, input logic or_v);
      for (int i = 0; i < N; i++) begin
         if (!pend_v[i] && v_en[i]) begin
            pend_v[i] = 1;
            pend_d[i] = nxt_data[i];
            pend_l[i] = nxt_last[i];
         end
         req_valid[i] = pend_v[i];
         req_data[i]  = pend_d[i];
         req_last[i]  = pend_l[i];
      end
      out_ready = or_v;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_vec[i]) begin
            pend_v[i] = 0;
            acc_cnt[i]++;
         end
      end
   endtask

   task automatic drain(input int n);
      for (int c = 0; c < n; c++) begin
         rand_next('1, 0);
         step(m_locked ? N'(1 << m_owner) : N'(0), 1'b1);
      end
   endtask

   task automatic send5(input logic [4:0] mask);
      logic [4:0] rem;
      logic [4:0] a;
      rem = mask;
      for (int c = 0; c < 20 && rem != '0; c++) begin
         v5 = rem;
         @(negedge clk);
         a = ready5 & v5;
         @(posedge clk);
         #1;
         rem = rem & ~a;
      end
      v5 = '0;
      chk("n5_grant_timeout", rem, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      req_valid = '1;
      req_last  = '1;
      for (int i = 0; i < N; i++) begin
         req_data[i] = $urandom;
         pend_v[i]   = 0;
         pend_d[i]   = '0;
         pend_l[i]   = 1'b0;
         acc_cnt[i]  = 0;
      end
      v5  = '0;
      l5  = '1;
      or5 = 1'b1;
      for (int i = 0; i < 5; i++) d5[i] = 32'h50 + 32'(i);

      // reset state, with every requester asking
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_locked", locked, 0);
      req_valid = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // round robin with everything valid and last
      for (int c = 0; c < 8; c++) begin
         rand_next('1, 0);
         step('1, 1'b1);
      end
      drain(4);

      // lock: requester 2 sends A0, A1, A2 while 0 and 1 wait
      base = acc_cnt[2];
      for (int c = 0; c < 20 && acc_cnt[2] < base + 3; c++) begin
         rand_next('1, 0);
         nxt_data[2] = 32'hA0 + 32'(acc_cnt[2] - base);
         nxt_last[2] = (acc_cnt[2] - base == 2);
         step((c == 0) ? N'(3'b100) : N'(3'b111), 1'b1);
      end
      chk("lock_beats", acc_cnt[2] - base, 3);
      drain(6);

      // backpressure
      rand_next('1, 0);
      step('1, 1'b1);
      for (int c = 0; c < 4; c++) step('1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         rand_next('1, 0);
         step('1, 1'b1);
      end
      drain(6);

      // owner gap: requester 0 locks, goes idle two cycles while 1 and 2 wait
      rand_next('1, 0);
      nxt_last[0] = 1'b0;
      step(3'b001, 1'b1);
      rand_next('1, 0);
      step(3'b110, 1'b1);
      step(3'b110, 1'b1);
      base = acc_cnt[0];
      for (int c = 0; c < 10 && acc_cnt[0] == base; c++) step(3'b111, 1'b1);
      chk("gap_resume", acc_cnt[0] - base, 1);
      drain(6);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         rand_next('0, 1);
         step(N'($urandom), $urandom_range(0, 3) != 0);
      end
      drain(12);
      chk("queue_empty_mid", exp_q.size(), 0);

      // reset in the middle of a locked transfer from requester 1
      base = acc_cnt[1];
      for (int c = 0; c < 10 && acc_cnt[1] < base + 2; c++) begin
         rand_next('0, 0);
         step(3'b010, 1'b1);
      end
      chk("prerst_beats", acc_cnt[1] - base, 2);
      chk("prerst_locked", locked, 1);
      #2 rst_n = 1'b0;
      req_valid = '1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_out_src", out_src, 0);
      chk("arst_out_last", out_last, 0);
      chk("arst_locked", locked, 0);
      chk("arst_req_ready", req_ready, 0);
      for (int i = 0; i < N; i++) pend_v[i] = 0;
      req_valid   = '0;
      m_ptr       = 0;
      m_owner     = 0;
      m_locked    = 0;
      m_out_valid = 0;
      acc_vec     = '0;
      exp_q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
         rand_next('1, 0);
         step('1, 1'b1);
      end
      drain(12);
      chk("queue_empty_end", exp_q.size(), 0);
      chk("all_idle", req_valid, 0);

      // N=5 wrap: 4 wraps ptr to 0; then {0,3} gives 0 then 3; 4 again; 3 alone from ptr 0
      exp5_q.push_back(3'd4);
      send5(5'b10000);
      exp5_q.push_back(3'd0);
      exp5_q.push_back(3'd3);
      send5(5'b01001);
      exp5_q.push_back(3'd4);
      send5(5'b10000);
      exp5_q.push_back(3'd3);
      send5(5'b01000);
      repeat (3) @(posedge clk);
      #1;
      chk("n5_queue_empty", exp5_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xmint_rr_arbiter.md
# xmint_rr_arbiter

Round-robin arbiter with a registered output stage. It shares one downstream data channel between N valid/ready requesters and sequences the select of the shared N:1 datapath mux. Multi-beat transfers are supported: a grant stays locked to one requester from its first beat until its `last` beat is accepted. The block sits between the requesting engines and any single-consumer resource in the xmint datapath.

## Interface
- `N`, default 3: number of requesters. Legal range is N >= 2.
- `MUX_DATA_WIDTH`, default 32: bit-width of each requester's data.
- `SEL_W`, default `$clog2(N)`: width of the source index. Localparam, not overridable.

- `clk`  in  1  Single clock; all state updates on its rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  N  Per-requester beat valid.
- `req_data`  in  N x MUX_DATA_WIDTH (packed `[N-1:0][MUX_DATA_WIDTH-1:0]`)  Per-requester beat data.
- `req_last`  in  N  Marks a requester's final beat of a transfer.
- `req_ready`  out  N  Per-requester accept. Combinational, one-hot or zero.
- `out_valid`  out  1  Output register holds a beat.
- `out_data`  out  MUX_DATA_WIDTH  Registered beat data.
- `out_src`  out  SEL_W  Index of the requester that supplied `out_data`.
- `out_last`  out  1  Registered copy of the beat's `req_last`.
- `out_ready`  in  1  Downstream accept.
- `locked`  out  1  High while a multi-beat transfer owns the grant.

## Operation
- **Handshakes.** A beat transfers when valid and ready are both high on a rising edge, on either side.
- **Requester rules.** Once `req_valid[i]` is raised, `req_data[i]` and `req_last[i]` must stay stable until `req_ready[i]`. Violations are a requester bug and are not checked.
- **Load enable.** `load_en = !out_valid || out_ready`. The output register is a full-throughput single stage.
- **State ARB (unlocked).**
  - The winner is the first index i with `req_valid[i]`, searching from `ptr` upward with wrap (ptr, ptr+1, …, N-1, 0, …, ptr-1).
  - `req_ready[winner] = load_en`.
- **State LOCKED.**
  - Only `owner` is eligible: `req_ready[owner] = load_en && req_valid[owner]`.
  - All other `req_ready` bits are 0, even when the owner is idle.
- **On an accepted beat from w:**
  - `out_data <= req_data[w]`, `out_src <= w`, `out_last <= req_last[w]`, `out_valid <= 1`.
  - If `req_last[w] = 1`: `ptr <= (w == N-1) ? 0 : w+1` and state goes to ARB.
  - Otherwise: `owner <= w` and state goes to LOCKED. `ptr` is unchanged.
- **No beat accepted but `out_ready` high:** `out_valid <= 0`.
- **Stall** (`out_valid && !out_ready`): all `req_ready` bits are 0, and the output registers, `ptr`, state and `owner` hold.
- **`locked`** equals (state == LOCKED).
- **Arithmetic.** `ptr` and `owner` are SEL_W bits wide and only ever take values 0..N-1. Wrap is explicit at N-1, not modulo 2^SEL_W, so non-power-of-two N never reaches an illegal index.
- **Reset.** Asserting `rst_n` mid-transfer aborts any lock immediately. No partial state survives.

## Timing
- **Reset values:** `out_valid` 0, `out_data` 0, `out_src` 0, `out_last` 0, `locked` 0, `ptr` 0, `owner` 0, state ARB.
- **During reset:** `req_ready` is all 0 (gated by reset state).
- **Latency:** one cycle, accept edge to `out_valid` visible.
- **Throughput:** one beat per cycle when `out_ready` is held high.
- **Combinational paths:** `req_ready` depends on `req_valid`, `out_ready` and registered state. There is no combinational path from `req_*` to `out_*`.
- **Simultaneous events:**
  - Downstream drain and new load in the same cycle: the load wins and `out_valid` stays 1.
  - A last beat accepted while other requesters are waiting: the next grant is arbitrated in the following cycle from the updated `ptr`.
- **Fairness:** a requester holding `req_valid` is granted within N-1 transfers, counting whole locked transfers as one.

## Test plan
- **Reset mid-lock.**
  - Stimulus: requester 1 sends two non-last beats, then `rst_n` is pulsed.
  - Required: all outputs return to reset values asynchronously. `locked` is 0, `ptr` is 0. The next grant with all valid high goes to 0.
- **Round-robin order.**
  - Stimulus: N=3, all `req_valid` and `req_last` held high, `out_ready` high.
  - Required: `out_src` sequence 0,1,2,0,1,2. One beat per cycle after one-cycle latency.
- **Lock.**
  - Stimulus: requester 2 sends beats 0xA0, 0xA1, 0xA2 (last on 0xA2), while 0 and 1 are also valid.
  - Required: three consecutive beats with `out_src` = 2 and `locked` = 1. `locked` drops after 0xA2. The next grant goes to 0.
- **Backpressure.**
  - Stimulus: `out_ready` = 0 for 4 cycles while `out_valid` = 1.
  - Required: `out_data`, `out_src` and `out_last` are stable, `req_ready` = 0. The beat drains on the first cycle `out_ready` = 1, and a new beat loads in that same cycle.
- **Owner gap.**
  - Stimulus: the locked owner deasserts `req_valid` for 2 cycles while others are valid.
  - Required: no grants to others. `out_valid` falls to 0 after the drain. The lock resumes with the owner.
- **Non-power-of-two wrap.**
  - Stimulus: N=5, single requester 4 sends a last beat.
  - Required: `ptr` becomes 0, never 5. Next, with 3 and 0 both valid, 0 is granted.
